// File: rtl/stream_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : stream_seq_pkg                                              |
// | Purpose  : Shared types and default widths for the stream sequencer.   |
// |            Holds the FSM state encoding (also exported on the debug    |
// |            state port) and the default counter widths.                 |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package stream_seq_pkg;

  localparam int DEF_CNT_W = 32;  // pattern count / progress counter
  localparam int DEF_WPP_W = 16;  // words per pattern
  localparam int DEF_GAP_W = 16;  // inter-pattern idle gap

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_STREAM = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/stream_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : stream_sequencer_if                                         |
// | Purpose  : Control/status and FIFO-side signals of the stream          |
// |            sequencer, bundled with master (controller) and slave       |
// |            (sequencer) views.                                          |
// | Signals  : start, abort, num_pat, words_per_pat, gap_cycles,           |
// |            fifo_empty   -> into the sequencer                          |
// |            stream_en, busy, done, pat_cnt, underrun, state             |
// |                         -> out of the sequencer                        |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface stream_sequencer_if
  import stream_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WPP_W = DEF_WPP_W,
  parameter int GAP_W = DEF_GAP_W
);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_pat;
  logic [WPP_W-1:0] words_per_pat;
  logic [GAP_W-1:0] gap_cycles;
  logic             fifo_empty;
  logic             stream_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pat_cnt;
  logic             underrun;
  logic [2:0]       state;

  modport master (
    output start, abort, num_pat, words_per_pat, gap_cycles, fifo_empty,
    input  stream_en, busy, done, pat_cnt, underrun, state
  );

  modport slave (
    input  start, abort, num_pat, words_per_pat, gap_cycles, fifo_empty,
    output stream_en, busy, done, pat_cnt, underrun, state
  );

endinterface
`default_nettype wire

// File: rtl/stream_sequencer_seq_down_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : seq_down_counter                                            |
// | Purpose  : Loadable down counter with zero flag. Load has priority     |
// |            over decrement; decrement holds at zero instead of wrapping.|
// | Ports    : clk, reset (async, active-high), i_load, i_load_val,        |
// |            i_dec, o_zero                                               |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module seq_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/stream_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : stream_sequencer                                            |
// | Purpose  : Drives the read enable of the pattern output FIFO. Plays    |
// |            num_pat patterns of words_per_pat words, separated by       |
// |            gap_cycles idle cycles, and reports progress, completion    |
// |            and FIFO underrun.                                          |
// | Ports    : clk, reset (async, active-high),                            |
// |            bus (stream_sequencer_if.slave)                             |
// | Config   : STREAM_SEQ_UNDERRUN_HALT_EN defined   -> underrun ends run  |
// |            STREAM_SEQ_UNDERRUN_HALT_EN undefined -> underrun stalls    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module stream_sequencer
  import stream_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WPP_W = DEF_WPP_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic              clk,
  input  logic              reset,
  stream_sequencer_if.slave bus
);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [CNT_W-1:0] r_num_pat;
  logic [CNT_W-1:0] r_pat_cnt;
  logic [CNT_W-1:0] w_pat_inc;
  logic [WPP_W-1:0] r_wpp_m1;
  logic [WPP_W-1:0] w_start_wpp_m1;
  logic [WPP_W-1:0] w_word_load_val;
  logic [GAP_W-1:0] r_gap;
  logic             r_underrun;
  logic             w_start_ok;
  logic             w_read;
  logic             w_word_zero;
  logic             w_gap_zero;
  logic             w_last_of_run;
  logic             w_pat_end;
  logic             w_word_load;
  logic             w_gap_load;

  assign w_start_ok     = (r_state == S_IDLE) && bus.start;
  // A zero-length pattern behaves as a one-word pattern.
  assign w_start_wpp_m1 = (bus.words_per_pat == '0) ? '0
                                                    : bus.words_per_pat - WPP_W'(1);

  // Saturating progress increment.
  assign w_pat_inc      = (&r_pat_cnt) ? r_pat_cnt : r_pat_cnt + CNT_W'(1);
  assign w_last_of_run  = w_word_zero && (w_pat_inc == r_num_pat);

  // abort suppresses the read, except on the very last word of the run,
  // which is allowed to complete.
  assign w_read    = (r_state == S_STREAM) && !bus.fifo_empty &&
                     (!bus.abort || w_last_of_run);
  assign w_pat_end = w_read && w_word_zero;

  // Word counter holds words remaining minus one; reloaded at start and at
  // the end of every pattern.
  assign w_word_load     = w_start_ok || w_pat_end;
  assign w_word_load_val = w_start_ok ? w_start_wpp_m1 : r_wpp_m1;

  seq_down_counter #(.WIDTH(WPP_W)) u_word_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_word_load),
    .i_load_val (w_word_load_val),
    .i_dec      (w_read),
    .o_zero     (w_word_zero)
  );

  // Gap counter is loaded with gap-1 on GAP entry; GAP exits on zero, which
  // yields exactly gap_cycles idle cycles.
  seq_down_counter #(.WIDTH(GAP_W)) u_gap_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_gap_load),
    .i_load_val (r_gap - GAP_W'(1)),
    .i_dec      (r_state == S_GAP),
    .o_zero     (w_gap_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_gap_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_ARM;
      end
      S_ARM: begin
        if (bus.abort || (r_num_pat == '0)) w_next = S_FINISH;
        else if (!bus.fifo_empty)           w_next = S_STREAM;
      end
      S_STREAM: begin
        if (w_pat_end) begin
          if (w_pat_inc == r_num_pat) begin
            w_next = S_FINISH;
          end else if (r_gap != '0) begin
            w_next     = S_GAP;
            w_gap_load = 1'b1;
          end
        end else if (bus.abort) begin
          w_next = S_FINISH;
`ifdef STREAM_SEQ_UNDERRUN_HALT_EN
        end else if (bus.fifo_empty) begin
          w_next = S_FINISH;
`endif
        end
      end
      S_GAP: begin
        if (bus.abort)       w_next = S_FINISH;
        else if (w_gap_zero) w_next = S_STREAM;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num_pat  <= '0;
      r_wpp_m1   <= '0;
      r_gap      <= '0;
      r_pat_cnt  <= '0;
      r_underrun <= 1'b0;
    end else if (w_start_ok) begin
      r_num_pat  <= bus.num_pat;
      r_wpp_m1   <= w_start_wpp_m1;
      r_gap      <= bus.gap_cycles;
      r_pat_cnt  <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_pat_end) r_pat_cnt <= w_pat_inc;
      // Any empty cycle while a pattern is in flight is an underrun.
      if ((r_state == S_STREAM) && bus.fifo_empty) r_underrun <= 1'b1;
    end
  end

  assign bus.stream_en = w_read;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_FINISH);
  assign bus.pat_cnt   = r_pat_cnt;
  assign bus.underrun  = r_underrun;
  assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stream_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_stream_sequencer                                         |
// | Purpose  : Self-checking bench for stream_sequencer. A pattern-level   |
// |            reference model (words left, gap left, patterns done)       |
// |            predicts every output each cycle; directed scenarios add    |
// |            literal expectations on read counts, spacing and latency.   |
// |            Honors STREAM_SEQ_UNDERRUN_HALT_EN like the design.         |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_stream_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  stream_sequencer_if bus ();

  stream_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          errors   = 0;
  int unsigned cyc      = 0;
  int unsigned rd_q[$];
  int          done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_phase uses the documented debug codes: 0 idle, 1 arm, 2 stream,
  // 3 gap, 4 finish.
  longint m_phase, m_num, m_wpp, m_gap, m_left, m_gap_left, m_cnt, m_under;
  bit     e_en;

  always @(negedge clk) begin
    if (reset) begin
      m_phase = 0; m_cnt = 0; m_under = 0;
      check("rst_stream_en", bus.stream_en, 0);
      check("rst_busy",      bus.busy,      0);
      check("rst_done",      bus.done,      0);
      check("rst_pat_cnt",   bus.pat_cnt,   0);
      check("rst_underrun",  bus.underrun,  0);
      check("rst_state",     bus.state,     0);
    end else begin
      e_en = (m_phase == 2) && !bus.fifo_empty &&
             (!bus.abort || (m_left == 1 && m_cnt + 1 == m_num));
      check("stream_en", bus.stream_en, e_en);
      check("busy",      bus.busy,      m_phase != 0);
      check("done",      bus.done,      m_phase == 4);
      check("pat_cnt",   bus.pat_cnt,   m_cnt);
      check("underrun",  bus.underrun,  m_under);
      check("state",     bus.state,     m_phase);
      if (bus.stream_en) rd_q.push_back(cyc);
      if (bus.done) done_cnt++;
      case (m_phase)
        0: if (bus.start) begin
          m_phase = 1;
          m_num   = bus.num_pat;
          m_wpp   = (bus.words_per_pat == 0) ? 1 : bus.words_per_pat;
          m_gap   = bus.gap_cycles;
          m_left  = m_wpp;
          m_cnt   = 0;
          m_under = 0;
        end
        1: begin
          if (bus.abort || m_num == 0) m_phase = 4;
          else if (!bus.fifo_empty)    m_phase = 2;
        end
        2: begin
          if (bus.fifo_empty) m_under = 1;
          if (e_en) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
              m_cnt  = m_cnt + 1;
              m_left = m_wpp;
              if (m_cnt == m_num) m_phase = 4;
              else if (m_gap != 0) begin
                m_phase    = 3;
                m_gap_left = m_gap;
              end
            end
          end else if (bus.abort) begin
            m_phase = 4;
`ifdef STREAM_SEQ_UNDERRUN_HALT_EN
          end else if (bus.fifo_empty) begin
            m_phase = 4;
`endif
          end
        end
        3: begin
          if (bus.abort) m_phase = 4;
          else begin
            m_gap_left = m_gap_left - 1;
            if (m_gap_left == 0) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n, input int w, input int g,
                             output int unsigned s);
    bus.num_pat       = 32'(n);
    bus.words_per_pat = 16'(w);
    bus.gap_cycles    = 16'(g);
    bus.start         = 1'b1;
    s = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus.busy && k < budget) begin
      tick();
      k++;
    end
    check("idle_within_budget", bus.busy, 0);
  endtask

  task automatic clear_obs();
    rd_q.delete();
    done_cnt = 0;
  endtask

  int unsigned s;

  initial begin
    bus.start = 0; bus.abort = 0; bus.fifo_empty = 0;
    bus.num_pat = 0; bus.words_per_pat = 0; bus.gap_cycles = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("post_rst_state", bus.state, 0);

    // 3 patterns x 4 words, gap 2, FIFO always full
    clear_obs();
    pulse_start(3, 4, 2, s);
    wait_idle(100);
    check("t1_reads",     rd_q.size(), 12);
    check("t1_first_lat", rd_q[0] - s, 2);
    check("t1_run_len",   rd_q[3] - rd_q[0], 3);
    check("t1_space_12",  rd_q[4] - rd_q[3], 3);
    check("t1_space_23",  rd_q[8] - rd_q[7], 3);
    check("t1_pat_cnt",   bus.pat_cnt, 3);
    check("t1_done_cnt",  done_cnt, 1);
    check("t1_underrun",  bus.underrun, 0);

    // num_pat = 0: ARM then FINISH, no reads
    clear_obs();
    pulse_start(0, 3, 1, s);
    check("t2_arm_state", bus.state, 1);
    tick();
    check("t2_done",      bus.done, 1);
    check("t2_done_cyc",  cyc - s, 2);
    tick();
    check("t2_idle",      bus.busy, 0);
    check("t2_reads",     rd_q.size(), 0);

    // words_per_pat = 0 acts as 1, back-to-back patterns
    clear_obs();
    pulse_start(2, 0, 0, s);
    wait_idle(50);
    check("t3_reads",     rd_q.size(), 2);
    check("t3_b2b",       rd_q[1] - rd_q[0], 1);
    check("t3_pat_cnt",   bus.pat_cnt, 2);

    // FIFO empty for 5 cycles after 3 words of an 8-word pattern
    clear_obs();
    pulse_start(1, 8, 0, s);
    repeat (4) tick();
    bus.fifo_empty = 1'b1;
    repeat (5) tick();
    bus.fifo_empty = 1'b0;
    wait_idle(100);
    check("t4_underrun",  bus.underrun, 1);
    check("t4_done_cnt",  done_cnt, 1);
`ifdef STREAM_SEQ_UNDERRUN_HALT_EN
    check("t4_reads",     rd_q.size(), 3);
    check("t4_pat_cnt",   bus.pat_cnt, 0);
`else
    check("t4_reads",     rd_q.size(), 8);
    check("t4_pat_cnt",   bus.pat_cnt, 1);
`endif

    // abort during the gap after pattern 1 of 4
    clear_obs();
    pulse_start(4, 2, 3, s);
    repeat (3) tick();
    check("t5_gap_state", bus.state, 3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5_done",      bus.done, 1);
    check("t5_pat_cnt",   bus.pat_cnt, 1);
    check("t5_stream_en", bus.stream_en, 0);
    tick();
    check("t5_idle",      bus.busy, 0);
    check("t5_reads",     rd_q.size(), 2);

    // asynchronous reset in STREAM, then a fresh run
    clear_obs();
    pulse_start(2, 3, 0, s);
    repeat (5) tick();
    check("t6_pre_pat_cnt", bus.pat_cnt, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_stream_en", bus.stream_en, 0);
    check("t6_async_busy",      bus.busy, 0);
    check("t6_async_state",     bus.state, 0);
    check("t6_async_pat_cnt",   bus.pat_cnt, 0);
    tick();
    reset = 1'b0;
    check("t6_no_done",   done_cnt, 0);
    clear_obs();
    pulse_start(2, 2, 1, s);
    wait_idle(50);
    check("t6_reads",     rd_q.size(), 4);
    check("t6_pat_cnt",   bus.pat_cnt, 2);
    check("t6_done_cnt",  done_cnt, 1);

    // randomized traffic; the per-cycle model does the checking
    for (int i = 0; i < 3000; i++) begin
      bus.start         = ($urandom_range(0, 15) == 0);
      bus.num_pat       = 32'($urandom_range(0, 4));
      bus.words_per_pat = 16'($urandom_range(0, 5));
      bus.gap_cycles    = 16'($urandom_range(0, 3));
      bus.fifo_empty    = ($urandom_range(0, 3) == 0);
      bus.abort         = ($urandom_range(0, 59) == 0);
      reset             = (i == 1500);
      tick();
    end
    reset = 1'b0;
    bus.start = 0; bus.abort = 0; bus.fifo_empty = 0;
    wait_idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_sequencer.md
# stream_sequencer

Sequencer that drives the read enable of the pattern-to-sensor output FIFO on the stream clock domain. It plays a programmed number of patterns, each a fixed number of 64-bit FIFO words. Patterns are separated by a programmable idle gap, and the block reports progress, completion and FIFO underrun. It replaces the free-running external stream enable. Its `stream_en` output feeds the FIFO `rd_en` and the 1-cycle-delayed sensor enable.

## Interface
- `CNT_W`, 32: width of pattern count and progress counter
- `WPP_W`, 16: width of words-per-pattern
- `GAP_W`, 16: width of inter-pattern gap

Ports:
- `clk` in 1: stream clock; the only clock
- `reset` in 1: asynchronous, active-high
- `start` in 1: 1-cycle pulse; begins a run from IDLE only
- `abort` in 1: level; ends a run
- `num_pat` in CNT_W: patterns per run; sampled at start
- `words_per_pat` in WPP_W: FIFO words per pattern; sampled at start; 0 treated as 1
- `gap_cycles` in GAP_W: idle cycles between patterns; sampled at start
- `fifo_empty` in 1: output FIFO empty flag, read side
- `stream_en` out 1: FIFO read enable
- `busy` out 1: run in progress
- `done` out 1: 1-cycle pulse at run end, normal or abort
- `pat_cnt` out CNT_W: patterns completed in the current or last run
- `underrun` out 1: sticky; cleared by start or reset
- `state` out 3: encoded FSM state, for debug

## Operation
States: IDLE, ARM, STREAM, GAP, FINISH. The only transitions:
- IDLE → ARM on `start`.
  - Latches `num_pat`, `words_per_pat` and `gap_cycles`.
  - Clears `pat_cnt` and `underrun`.
- ARM → FINISH if latched `num_pat`==0.
- ARM → STREAM once `fifo_empty`==0.
- STREAM:
  - `stream_en` = !`fifo_empty`. This is the only combinational output.
  - Each cycle with `stream_en`=1 decrements the word counter.
  - When the counter reaches the last word and a read occurs, `pat_cnt` increments.
  - Then → GAP if `gap_cycles`≠0 and patterns remain.
  - Or → STREAM, reloading the word counter, if the gap is 0 and patterns remain.
  - Or → FINISH if no patterns remain.
- GAP: counts `gap_cycles` cycles with `stream_en`=0, then → STREAM.
- FINISH: `done`=1 for one cycle, then → IDLE.
- `abort` in ARM, STREAM or GAP → FINISH next cycle. `stream_en` is 0 in the abort cycle.
- `busy` = state ∉ {IDLE}.
- `start` is ignored while `busy`.
- `pat_cnt` holds its value in IDLE.

Underrun: `fifo_empty`=1 in STREAM with words remaining sets `underrun`. The response depends on the macro; see Configuration.

Arithmetic:
- Counters are unsigned.
- Word counter loads `words_per_pat`−1 (0→0).
- `pat_cnt` saturates at 2^CNT_W−1; it never wraps.
- Runs end on the equality `pat_cnt`==latched `num_pat`.

## Timing
- Reset values: `stream_en`=0, `busy`=0, `done`=0, `pat_cnt`=0, `underrun`=0, `state`=IDLE.
- Reset mid-run forces IDLE asynchronously, with no `done` pulse.
- Latency:
  - `start` at cycle 0 → ARM at cycle 1.
  - First `stream_en`=1 at cycle 2 if the FIFO is non-empty.
- Reads per pattern: exactly `words_per_pat` cycles of `stream_en`=1.
- Gap length: the gap between the last read of pattern n and the first read of pattern n+1 is `gap_cycles`+1 cycles.
- Simultaneous events:
  - `abort` with the last word of the run: the read completes, `pat_cnt` increments, FINISH follows.
  - `start` in the FINISH cycle is ignored.

## Configuration
Macro: `STREAM_SEQ_UNDERRUN_HALT_EN`.
- Defined: the first underrun cycle in STREAM → FINISH. The run ends with `done` and `underrun`=1.
- Undefined: STREAM stalls with `stream_en`=0 until `fifo_empty` drops, then resumes the same pattern. `underrun` still sets.

## Structure
- Package `stream_seq_pkg` holds:
  - the state enum with encodings IDLE=0, ARM=1, STREAM=2, GAP=3, FINISH=4;
  - default widths `CNT_W`, `WPP_W` and `GAP_W`.
- Sub-module `seq_down_counter`, parameterized width, with load, decrement and zero flag.
- It is instantiated twice: once for the word counter and once for the gap counter.
- The top level holds the FSM, `pat_cnt` and the flags.

## Test plan
- `num_pat`=3, `words_per_pat`=4, `gap_cycles`=2, FIFO never empty → 12 read cycles in runs of 4 with 3-cycle spacing, `pat_cnt`=3, one `done`, `underrun`=0.
- `num_pat`=0, `start` → ARM, FINISH, `done` at cycle 2, no `stream_en`.
- `words_per_pat`=0, `num_pat`=2, `gap_cycles`=0 → exactly 2 back-to-back reads, `pat_cnt`=2.
- `fifo_empty` high for 5 cycles mid-pattern (`words_per_pat`=8):
  - macro undefined → stall, total 8 reads, `underrun`=1;
  - macro defined → FINISH next cycle, `pat_cnt`=0.
- `abort` during GAP after pattern 1 of 4 → `done` next cycle, `pat_cnt`=1, `stream_en` stays 0.
- `reset` asserted in STREAM → all outputs at reset values asynchronously; a new `start` runs normally.
